// File: rtl/fft_top_mul_arb_pkg.sv
// Shared widths, pipeline tag type and the round-robin picker for the shared FFT multiplier.
// The picker works on a fixed 8-wide request vector; callers zero-pad and use the low NREQ bits.
package fft_top_mul_arb_pkg;
  localparam int A_W          = 18;
  localparam int B_W          = 15;
  localparam int P_W          = A_W + B_W;
  localparam int NREQ_DEFAULT = 4;
  localparam int MAX_REQ      = 8;
  localparam int TAG_ID_W     = 3;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

  // First valid requester after ptr, wrapping modulo n; returns a one-hot (or zero) grant.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                 input logic [TAG_ID_W-1:0] ptr,
                                                 input int                  n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k <= n && !found && valid[idx[TAG_ID_W-1:0]]) begin
        grant[idx[TAG_ID_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction
endpackage

// File: rtl/fft_top_mul_arb_pipe.sv
// Two-stage signed multiplier (A/B input registers, P output register) carrying a valid/id tag.
// Result appears two clocks after capture; ce low freezes every register, tags included.
module fft_top_mul_arb_pipe
  import fft_top_mul_arb_pkg::*;
#(
  parameter int A_W = fft_top_mul_arb_pkg::A_W,
  parameter int B_W = fft_top_mul_arb_pkg::B_W,
  parameter int P_W = fft_top_mul_arb_pkg::P_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [A_W-1:0]        a,
  input  logic [B_W-1:0]        b,
  input  mul_tag_t              tag_in,
  output logic signed [P_W-1:0] p,
  output mul_tag_t              tag_out
);
  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic signed [P_W-1:0] p_q;
  mul_tag_t              tag1_q;
  mul_tag_t              tag2_q;

  // Operand registers only load on a real grant so idle cycles keep the DSP inputs quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else if (ce) begin
      if (tag_in.v) begin
        a_q <= a;
        b_q <= b;
      end
      tag1_q <= tag_in;
      p_q    <= P_W'(a_q) * P_W'(b_q);
      tag2_q <= tag1_q;
    end
  end

  assign p       = p_q;
  assign tag_out = tag2_q;
endmodule

// File: rtl/fft_top_mul_arb.sv
// Round-robin arbiter sharing one pipelined 18x15 multiplier among NREQ requesters; 2-cycle latency.
// A stalled result (res_valid & ~res_ready) freezes the pipeline and withholds every grant.
module fft_top_mul_arb
  import fft_top_mul_arb_pkg::*;
#(
  parameter int NREQ = fft_top_mul_arb_pkg::NREQ_DEFAULT,
  parameter int A_W  = fft_top_mul_arb_pkg::A_W,
  parameter int B_W  = fft_top_mul_arb_pkg::B_W,
  parameter int P_W  = fft_top_mul_arb_pkg::P_W,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*A_W-1:0]   req_a,
  input  logic [NREQ*B_W-1:0]   req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [P_W-1:0]        res_data,
  output logic [ID_W-1:0]       res_id,
  input  logic                  res_ready
);
  logic                  ce;
  logic                  hs;
  logic [TAG_ID_W-1:0]   ptr_q;
  logic [TAG_ID_W-1:0]   ptr_d;
  logic [TAG_ID_W-1:0]   grant_idx;
  logic [MAX_REQ-1:0]    valid_ext;
  logic [MAX_REQ-1:0]    pick;
  logic [NREQ-1:0]       grant;
  logic [A_W-1:0]        a_sel;
  logic [B_W-1:0]        b_sel;
  mul_tag_t              tag_in;
  mul_tag_t              tag_out;
  logic signed [P_W-1:0] p;
  logic                  unused_hi;

  assign ce = ~res_valid | res_ready;

  always_comb begin
    valid_ext            = '0;
    valid_ext[NREQ-1:0]  = req_valid;
    pick                 = rr_pick(valid_ext, ptr_q, NREQ);
    grant                = pick[NREQ-1:0];
    req_ready            = (ce && !reset) ? grant : '0;
    hs                   = |(req_ready & req_valid);
    grant_idx            = '0;
    a_sel                = '0;
    b_sel                = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx = TAG_ID_W'(i);
        a_sel     = req_a[i*A_W +: A_W];
        b_sel     = req_b[i*B_W +: B_W];
      end
    end
    ptr_d     = hs ? grant_idx : ptr_q;
    tag_in.v  = hs;
    tag_in.id = grant_idx;
  end

  // Pointer parks on the last winner; NREQ-1 after reset makes requester 0 first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= TAG_ID_W'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  fft_top_mul_arb_pipe #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .a       (a_sel),
    .b       (b_sel),
    .tag_in  (tag_in),
    .p       (p),
    .tag_out (tag_out)
  );

  assign res_valid = tag_out.v;
  assign res_data  = p;
  assign res_id    = tag_out.id[ID_W-1:0];
  assign unused_hi = ^{pick, tag_out.id};
endmodule

// File: tb/tb_fft_top_mul_arb.sv
// Scoreboard bench: expected products are queued at each request handshake and popped on every
// accepted result; directed cases cover latency, grant order, extremes, stall hold and mid-run reset.
module tb_fft_top_mul_arb;
  localparam int NREQ = 4;

  typedef struct packed {
    logic [32:0] p;
    logic [1:0]  id;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*18-1:0] req_a;
  logic [NREQ*15-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [32:0]        res_data;
  logic [1:0]         res_id;

  logic signed [17:0] ra [NREQ];
  logic signed [14:0] rb [NREQ];
  logic [32:0]        ep [NREQ];
  logic [NREQ-1:0]    oneshot = '1;
  logic [NREQ-1:0]    drop = '0;

  exp_t               sb [$];
  int                 checks = 0;
  int                 errors = 0;

  int                 wait_cnt [NREQ] = '{default: 0};
  logic [NREQ-1:0]    prev_pend = '0;
  logic signed [17:0] prev_a [NREQ];
  logic signed [14:0] prev_b [NREQ];
  logic               prev_stall = 1'b0;
  logic [32:0]        prev_data = '0;
  logic [1:0]         prev_id = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*18 +: 18] = ra[i];
      req_b[i*15 +: 15] = rb[i];
    end
  end

  fft_top_mul_arb dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Monitor: output side pops and compares, request side pushes expectations and tracks fairness.
  always @(negedge clk) begin
    exp_t e;
    logic hs_any;
    if (reset) begin
      sb.delete();
      prev_stall = 1'b0;
      prev_pend  = '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      chk("ready_in_reset", 64'(req_ready), 64'd0);
    end else begin
      if (prev_stall)
        chk("stall_hold", 64'({res_valid, res_id, res_data}), 64'({1'b1, prev_id, prev_data}));
      if (res_valid && !res_ready)
        chk("stall_no_grant", 64'(req_ready), 64'd0);
      prev_stall = res_valid & ~res_ready;
      prev_data  = res_data;
      prev_id    = res_id;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data 0x%0h id %0d, expected none", res_data, res_id);
        end else begin
          e = sb.pop_front();
          chk("res_data", 64'(res_data), 64'(e.p));
          chk("res_id", 64'(res_id), 64'(e.id));
        end
      end
      hs_any = |(req_valid & req_ready);
      for (int i = 0; i < NREQ; i++) begin
        if (prev_pend[i] && req_valid[i])
          chk("req_operands_stable", 64'({ra[i], rb[i]}), 64'({prev_a[i], prev_b[i]}));
        if (req_valid[i] && req_ready[i]) begin
          chk("fair_wait_le_3", 64'(wait_cnt[i] <= NREQ - 1), 64'd1);
          wait_cnt[i] = 0;
          sb.push_back('{p: ep[i], id: 2'(i)});
          if (oneshot[i]) drop[i] = 1'b1;
        end else if (req_valid[i]) begin
          if (hs_any) wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
        prev_pend[i] = req_valid[i] & ~req_ready[i];
        prev_a[i]    = ra[i];
        prev_b[i]    = rb[i];
      end
    end
  end

  // One-shot requesters drop valid right after their handshake edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (drop[i]) begin
        req_valid[i] = 1'b0;
        drop[i]      = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int i, input logic signed [17:0] a, input logic signed [14:0] b,
                       input logic [32:0] e);
    int n;
    n = 0;
    while (req_valid[i] && n < 100) begin
      tick();
      n++;
    end
    chk("issue_wait", 64'(n < 100), 64'd1);
    ra[i]        = a;
    rb[i]        = b;
    ep[i]        = e;
    req_valid[i] = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0 || res_valid) && n < 300) begin
      tick();
      n++;
    end
    chk(name, 64'(n < 300), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0]    exp_g;
    logic signed [17:0] a;
    logic signed [14:0] b;
    logic signed [32:0] prod;

    reset     = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      ep[i] = '0;
    end
    tick();
    tick();
    @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    tick();
    reset = 1'b0;

    // Single request: 3 * -5 = -15, one grant cycle, result two edges after the handshake.
    issue(0, 18'sd3, -15'sd5, -33'sd15);
    @(negedge clk);
    chk("t1_grant", 64'(req_ready), 64'd1);
    tick();
    @(negedge clk);
    chk("t1_lat1_valid", 64'(res_valid), 64'd0);
    chk("t1_ready_drop", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("t1_lat2_valid", 64'(res_valid), 64'd1);
    drain("t1_drain");

    // All requesters valid from reset: grants 0,1,2,3,0,... with products 10,20,30,40.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 18'(i + 1);
      rb[i] = 15'sd10;
      ep[i] = 33'(10 * (i + 1));
    end
    oneshot   = '0;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_g = 4'b0001 << (k % 4);
      chk("rr_grant", 64'(req_ready), 64'(exp_g));
      if (k >= 2) chk("rr_one_per_cycle", 64'(res_valid), 64'd1);
      tick();
    end
    oneshot = '1;
    drain("t2_drain");

    // Operand extremes.
    issue(3, 18'sh20000, 15'sh4000, 33'h080000000);
    issue(3, 18'sd131071, 15'sd16383, 33'd2147336193);
    drain("t3_drain");

    // Two products in flight, then five stalled cycles; ptr=3 so requester 1 wins first.
    issue(1, 18'sd7, 15'sd3, 33'd21);
    issue(2, -18'sd4, 15'sd9, -33'sd36);
    tick();
    tick();
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_valid", 64'(res_valid), 64'd1);
      chk("stall_data", 64'(res_data), 64'd21);
      chk("stall_id", 64'(res_id), 64'd1);
      tick();
    end
    res_ready = 1'b1;
    drain("t4_drain");

    // Continuous traffic, then a single-edge reset mid-stream.
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 18'(i + 1);
      rb[i] = -15'sd7;
      ep[i] = 33'(-7 * (i + 1));
    end
    oneshot   = '0;
    req_valid = '1;
    repeat (6) tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_first_grant", 64'(req_ready), 64'd1);
    oneshot = '1;
    drain("t5_drain");

    // Random request/backpressure traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            a            = 18'($urandom);
            b            = 15'($urandom);
            prod         = 33'(a) * 33'(b);
            ra[i]        = a;
            rb[i]        = b;
            ep[i]        = prod;
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    res_ready = 1'b1;
    drain("final_drain");
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
